mont_domain_conv: RTL and testbench

//   Converts one operand into or out of the Montgomery domain for the 4096-bit RSA datapath.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/mont_bit_step.sv | 27 ++
 rtl/mont_domain_conv.sv | 123 ++++++++++++
 tb/tb_mont_domain_conv.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   RSA_W           : operand/modulus width of the production datapath (R = 2^RSA_W)
//   DIR_TO/DIR_FROM : Montgomery conversion direction encodings
//   state_t         : FSM encoding shared by the bit-serial Montgomery engines
package rsa_pkg;
    localparam int   RSA_W    = 4096;
    localparam logic DIR_TO   = 1'b0;
    localparam logic DIR_FROM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } state_t;
endpackage

// File: rtl/mont_bit_step.sv
// One iteration of the bit-serial interleaved Montgomery multiplier (combinational).
//   acc      in  W+2  running accumulator, acc < 2n
//   b        in  W    multiplicand
//   n        in  W    odd modulus
//   xbit     in  1    current multiplier bit (LSB first)
//   acc_next out W+2  (acc + xbit*b + q*n) / 2, q chosen to make the sum even
// Kept separate so the exponentiator can reuse the same step and so the
// two ripple adds can be timed as one isolated path.
module mont_bit_step #(
    parameter int W = 4096
) (
    input  logic [W+1:0] acc,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    input  logic         xbit,
    output logic [W+1:0] acc_next
);
    logic [W+1:0] t_add;
    logic [W+1:0] t_red;

    always_comb begin
        t_add    = acc + (xbit ? {2'b00, b} : '0);
        // Adding n when odd makes the sum exactly divisible by 2 (n is odd).
        t_red    = t_add + (t_add[0] ? {2'b00, n} : '0);
        acc_next = {1'b0, t_red[W+1:1]};
    end
endmodule

// File: rtl/mont_domain_conv.sv
// Montgomery domain converter for the RSA datapath.
//   to-domain   (dir=0): result = MontMul(x, r2) = x*R mod n
//   from-domain (dir=1): result = MontMul(x, 1)  = x*R^-1 mod n
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only in IDLE (and not in the done cycle)
//   dir, x, n, r2    operands, latched on an accepted start
//   result           converted value, held until overwritten by the next done
//   busy             high from the cycle after an accepted start until done
//   done             one-cycle completion pulse
//   err              one-cycle pulse with done when n is even
// Build option: define MONT_DOMAIN_CONV_ODD_CHECK_EN to reject even moduli
// immediately (done+err after one cycle, result 0). Without it err is tied 0.
module mont_domain_conv
    import rsa_pkg::*;
#(
    parameter int W     = RSA_W,
    parameter int CNT_W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic [W-1:0] x,
    input  logic [W-1:0] n,
    input  logic [W-1:0] r2,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         err
);
    state_t           state;
    logic [W-1:0]     xs;
    logic [W-1:0]     n_q;
    logic [W-1:0]     b_q;
    logic [W+1:0]     acc;
    logic [W+1:0]     acc_next;
    logic [CNT_W-1:0] cnt;
    logic             acc_ge_n;

    mont_bit_step #(.W(W)) u_step (
        .acc      (acc),
        .b        (b_q),
        .n        (n_q),
        .xbit     (xs[0]),
        .acc_next (acc_next)
    );

    // acc < 2n, so one conditional subtract fully reduces; the low W bits
    // of acc - n are exact whenever acc >= n.
    assign acc_ge_n = (acc >= {2'b00, n_q});

`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            xs     <= '0;
            n_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // done is registered on the FINAL->IDLE edge, so the done
                    // cycle is spent in IDLE; a start there is dropped.
                    if (start && !done) begin
                        xs   <= x;
                        n_q  <= n;
                        b_q  <= (dir == DIR_FROM) ? W'(1) : r2;
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
                        if (!n[0]) state <= FINAL;
                        else       state <= ITER;
`else
                        state <= ITER;
`endif
                    end
                end
                ITER: begin
                    acc <= acc_next;
                    xs  <= xs >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) state <= FINAL;
                end
                FINAL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
                    if (!n_q[0]) begin
                        result <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        result <= acc_ge_n ? (acc[W-1:0] - n_q) : acc[W-1:0];
                    end
`else
                    result <= acc_ge_n ? (acc[W-1:0] - n_q) : acc[W-1:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_domain_conv.sv
// Directed + random bench for mont_domain_conv: a W=8 instance for the
// directed vectors and a W=64 instance for random round-trip checks.
module tb_mont_domain_conv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          chk_res;
        int          st;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];

    // W=8 instance
    logic       start8 = 1'b0, dir8 = 1'b0;
    logic [7:0] x8 = '0, n8 = '0, r28 = '0, res8;
    logic       busy8, done8, err8;

    mont_domain_conv #(.W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dir(dir8),
        .x(x8), .n(n8), .r2(r28), .result(res8),
        .busy(busy8), .done(done8), .err(err8)
    );

    // W=64 instance
    logic        start64 = 1'b0, dir64 = 1'b0;
    logic [63:0] x64 = '0, n64 = '0, r264 = '0, res64;
    logic        busy64, done64, err64;

    mont_domain_conv #(.W(64), .CNT_W(7)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .dir(dir64),
        .x(x64), .n(n64), .r2(r264), .result(res64),
        .busy(busy64), .done(done64), .err(err64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop and compare on every done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done8) begin
                checks++;
                assert (q8.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_done8 got done exp none");
                end
                if (q8.size() != 0) begin
                    exp_t e;
                    e = q8.pop_front();
                    if (e.chk_res) chk("result8", {56'd0, res8}, e.res);
                    chk("err8", {63'd0, err8}, {63'd0, e.err});
                    chk("latency8", 64'(cyc - e.st), 64'(e.lat));
                end
            end else begin
                chk("err8_idle", {63'd0, err8}, 64'd0);
            end
            if (done64) begin
                checks++;
                assert (q64.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_done64 got done exp none");
                end
                if (q64.size() != 0) begin
                    exp_t e;
                    e = q64.pop_front();
                    chk("result64", res64, e.res);
                    chk("err64", {63'd0, err64}, 64'd0);
                    chk("latency64", 64'(cyc - e.st), 64'(e.lat));
                end
            end
        end
    end

    // Drive one accepted start on dut8 and push its expectation.
    task automatic run8(input logic d, input logic [7:0] xx, input logic [7:0] nn,
                        input logic [7:0] rr, input logic [7:0] er, input logic ee,
                        input int lat, input bit cr);
        exp_t e;
        @(negedge clk);
        dir8 = d; x8 = xx; n8 = nn; r28 = rr; start8 = 1'b1;
        e.res = {56'd0, er}; e.err = ee; e.lat = lat; e.chk_res = cr; e.st = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        // operands may change after the start edge
        x8 = 8'($urandom); n8 = 8'($urandom); r28 = 8'($urandom); dir8 = ~d;
    endtask

    task automatic wait8();
        int i = 0;
        while (!done8 && i < 200) begin
            @(negedge clk);
            i++;
        end
        checks++;
        assert (done8) else begin
            errors++;
            $error("FAIL timeout8 got no done exp done");
        end
    endtask

    task automatic run64(input logic d, input logic [63:0] xx, input logic [63:0] nn,
                         input logic [63:0] rr, input logic [63:0] er);
        exp_t e;
        int i = 0;
        @(negedge clk);
        dir64 = d; x64 = xx; n64 = nn; r264 = rr; start64 = 1'b1;
        e.res = er; e.err = 1'b0; e.lat = 65; e.chk_res = 1'b1; e.st = cyc + 1;
        q64.push_back(e);
        @(negedge clk);
        start64 = 1'b0;
        x64 = {$urandom, $urandom};
        while (!done64 && i < 400) begin
            @(negedge clk);
            i++;
        end
        checks++;
        assert (done64) else begin
            errors++;
            $error("FAIL timeout64 got no done exp done");
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rmod64(input logic [63:0] nn);
        logic [127:0] r;
        r = (128'd1 << 64) % {64'd0, nn};
        return r[63:0];
    endfunction

    function automatic logic [63:0] mulmod64(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] nn);
        logic [127:0] p;
        p = ({64'd0, a} * {64'd0, b}) % {64'd0, nn};
        return p[63:0];
    endfunction

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_result", {56'd0, res8}, 64'd0);
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_err", {63'd0, err8}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic to/from vectors, R=256, n=13
        run8(1'b0, 8'd5, 8'd13, 8'd3, 8'd6, 1'b0, 9, 1'b1);
        chk("busy_running", {63'd0, busy8}, 64'd1);
        wait8(); @(negedge clk);
        chk("busy_after", {63'd0, busy8}, 64'd0);
        run8(1'b1, 8'd6, 8'd13, 8'd7, 8'd5, 1'b0, 9, 1'b1);  wait8(); @(negedge clk);
        run8(1'b0, 8'd0, 8'd13, 8'd3, 8'd0, 1'b0, 9, 1'b1);  wait8(); @(negedge clk);
        run8(1'b0, 8'd12, 8'd13, 8'd3, 8'd4, 1'b0, 9, 1'b1); wait8(); @(negedge clk);
        run8(1'b1, 8'd4, 8'd13, 8'd3, 8'd12, 1'b0, 9, 1'b1); wait8(); @(negedge clk);

        // start while busy is ignored
        run8(1'b0, 8'd5, 8'd13, 8'd3, 8'd6, 1'b0, 9, 1'b1);
        repeat (2) @(negedge clk);
        start8 = 1'b1; dir8 = 1'b1; x8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        wait8();
        // start in the done cycle is ignored; start the cycle after is taken
        start8 = 1'b1; dir8 = 1'b0; x8 = 8'd1; n8 = 8'd13; r28 = 8'd3;
        @(negedge clk);
        begin
            exp_t e;
            e.res = 64'd9; e.err = 1'b0; e.lat = 9; e.chk_res = 1'b1; e.st = cyc + 1;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        wait8(); @(negedge clk);

        // reset mid-operation at iteration 4
        run8(1'b0, 8'd12, 8'd13, 8'd3, 8'd4, 1'b0, 9, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("midrst_result", {56'd0, res8}, 64'd0);
        chk("midrst_busy", {63'd0, busy8}, 64'd0);
        chk("midrst_done", {63'd0, done8}, 64'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run8(1'b1, 8'd6, 8'd13, 8'd3, 8'd5, 1'b0, 9, 1'b1); wait8(); @(negedge clk);

        // even modulus
`ifdef MONT_DOMAIN_CONV_ODD_CHECK_EN
        run8(1'b0, 8'd5, 8'd12, 8'd4, 8'd0, 1'b1, 1, 1'b1);
`else
        run8(1'b0, 8'd5, 8'd12, 8'd4, 8'd0, 1'b0, 9, 1'b0);
`endif
        wait8(); @(negedge clk);

        // W=64 random round trip
        for (int k = 0; k < 8; k++) begin
            logic [63:0] nn, xx, rm, rr, yy;
            nn = {$urandom, $urandom} | 64'd1;
            if (nn < 64'd3) nn = 64'd3;
            xx = {$urandom, $urandom} % nn;
            rm = rmod64(nn);
            rr = mulmod64(rm, rm, nn);
            yy = mulmod64(xx, rm, nn);
            run64(1'b0, xx, nn, rr, yy);
            run64(1'b1, yy, nn, 64'($urandom), xx);
        end

        repeat (5) @(negedge clk);
        chk("q8_empty", 64'(q8.size()), 64'd0);
        chk("q64_empty", 64'(q64.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
